// File: rtl/axi3_pkg.sv
// Shared AXI3 constants, response codes and channel state types for the HP0
// stand-in responder.
package axi3_pkg;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [2:0] SIZE_8B     = 3'b011;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_DATA,
        R_GAP
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_t;

    // Only full-width INCR bursts are served; anything else answers SLVERR.
    function automatic logic burst_err(input logic [1:0] burst, input logic [2:0] size);
        return (burst != BURST_INCR) || (size != SIZE_8B);
    endfunction

endpackage

// File: rtl/mem_bram_2p.sv
// Simple dual-port block RAM: byte-enabled write port, registered read port.
// A read and write to the same word in one cycle returns the old contents.
module mem_bram_2p #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
        if (we) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (wr_be[b]) begin
                    mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/axi3_hp_slave_mem.sv
// AXI3 64-bit responder standing in for the Zynq HP0 port and DDR; INCR bursts
// only, one outstanding burst per direction, served from on-chip RAM.
//
// state  | meaning
// R_IDLE | ARREADY high, waiting for an AR handshake
// R_WAIT | read latency countdown
// R_DATA | RVALID high, beat held until RREADY
// R_GAP  | one dead cycle while the next word is fetched
// W_IDLE | AWREADY high, waiting for an AW handshake
// W_DATA | WREADY high, accepting beats until the count runs out
// W_RESP | BVALID high until BREADY
module axi3_hp_slave_mem
    import axi3_pkg::*;
#(
    parameter int AXIM_DATA_WIDTH = 64,
    parameter int AXIM_ADDR_WIDTH = 32,
    parameter int ID_WIDTH        = 6,
    parameter int MEM_ADDR_WIDTH  = 12,
    parameter int RD_LATENCY      = 4
) (
    input  logic                         ACLK,
    input  logic                         ARESETN,

    input  logic [AXIM_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [ID_WIDTH-1:0]          S_AXI_ARID,
    input  logic [3:0]                   S_AXI_ARLEN,
    input  logic [2:0]                   S_AXI_ARSIZE,
    input  logic [1:0]                   S_AXI_ARBURST,
    input  logic                         S_AXI_ARVALID,
    output logic                         S_AXI_ARREADY,

    output logic [AXIM_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [ID_WIDTH-1:0]          S_AXI_RID,
    output logic [1:0]                   S_AXI_RRESP,
    output logic                         S_AXI_RLAST,
    output logic                         S_AXI_RVALID,
    input  logic                         S_AXI_RREADY,

    input  logic [AXIM_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [ID_WIDTH-1:0]          S_AXI_AWID,
    input  logic [3:0]                   S_AXI_AWLEN,
    input  logic [2:0]                   S_AXI_AWSIZE,
    input  logic [1:0]                   S_AXI_AWBURST,
    input  logic                         S_AXI_AWVALID,
    output logic                         S_AXI_AWREADY,

    input  logic [AXIM_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [AXIM_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                         S_AXI_WLAST,
    input  logic                         S_AXI_WVALID,
    output logic                         S_AXI_WREADY,

    output logic [ID_WIDTH-1:0]          S_AXI_BID,
    output logic [1:0]                   S_AXI_BRESP,
    output logic                         S_AXI_BVALID,
    input  logic                         S_AXI_BREADY
);

    localparam int LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    rd_state_t                     rd_state;
    logic [ID_WIDTH-1:0]           rid_q;
    logic [MEM_ADDR_WIDTH-1:0]     rd_idx;
    logic [3:0]                    rd_cnt;
    logic                          rd_err;
    logic [LAT_W-1:0]              lat_cnt;
    logic                          arready_q, rvalid_q, rlast_q;
    logic [1:0]                    rresp_q;

    wr_state_t                     wr_state;
    logic [ID_WIDTH-1:0]           bid_q;
    logic [MEM_ADDR_WIDTH-1:0]     wr_idx;
    logic [3:0]                    wr_cnt;
    logic                          wr_err, wlast_err;
    logic                          awready_q, wready_q, bvalid_q;
    logic [1:0]                    bresp_q;

    logic                          ar_hs, aw_hs, w_hs;
    logic [MEM_ADDR_WIDTH-1:0]     ar_idx, aw_idx;
    logic                          mem_rd_en, mem_we;
    logic [MEM_ADDR_WIDTH-1:0]     mem_rd_addr;
    logic [AXIM_DATA_WIDTH-1:0]    mem_q;
    logic                          unused_addr_bits;

    assign ar_hs  = S_AXI_ARVALID && arready_q;
    assign aw_hs  = S_AXI_AWVALID && awready_q;
    assign w_hs   = S_AXI_WVALID && wready_q;
    assign ar_idx = S_AXI_ARADDR[MEM_ADDR_WIDTH+2:3];
    assign aw_idx = S_AXI_AWADDR[MEM_ADDR_WIDTH+2:3];

    assign unused_addr_bits = ^{S_AXI_ARADDR[AXIM_ADDR_WIDTH-1:MEM_ADDR_WIDTH+3], S_AXI_ARADDR[2:0],
                                S_AXI_AWADDR[AXIM_ADDR_WIDTH-1:MEM_ADDR_WIDTH+3], S_AXI_AWADDR[2:0]};

    // First word is fetched on the AR handshake itself so RD_LATENCY=1 works.
    always_comb begin
        mem_rd_en   = ARESETN && (ar_hs || (rd_state == R_GAP));
        mem_rd_addr = ar_hs ? ar_idx : rd_idx;
        mem_we      = ARESETN && w_hs && !wr_err;
    end

    mem_bram_2p #(
        .ADDR_WIDTH (MEM_ADDR_WIDTH),
        .DATA_WIDTH (AXIM_DATA_WIDTH)
    ) u_mem (
        .clk     (ACLK),
        .we      (mem_we),
        .wr_addr (wr_idx),
        .wr_be   (S_AXI_WSTRB),
        .wr_data (S_AXI_WDATA),
        .rd_en   (mem_rd_en),
        .rd_addr (mem_rd_addr),
        .rd_data (mem_q)
    );

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            rd_state  <= R_IDLE;
            rid_q     <= '0;
            rd_idx    <= '0;
            rd_cnt    <= '0;
            rd_err    <= 1'b0;
            lat_cnt   <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= RESP_OKAY;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (ar_hs) begin
                        arready_q <= 1'b0;
                        rid_q     <= S_AXI_ARID;
                        rd_idx    <= ar_idx;
                        rd_cnt    <= S_AXI_ARLEN;
                        rd_err    <= burst_err(S_AXI_ARBURST, S_AXI_ARSIZE);
                        rresp_q   <= burst_err(S_AXI_ARBURST, S_AXI_ARSIZE) ? RESP_SLVERR : RESP_OKAY;
                        lat_cnt   <= LAT_W'(RD_LATENCY - 1);
                        if (RD_LATENCY == 1) begin
                            rd_state <= R_DATA;
                            rvalid_q <= 1'b1;
                            rlast_q  <= (S_AXI_ARLEN == 4'd0);
                        end else begin
                            rd_state <= R_WAIT;
                        end
                    end
                end
                R_WAIT: begin
                    if (lat_cnt <= LAT_W'(1)) begin
                        rd_state <= R_DATA;
                        rvalid_q <= 1'b1;
                        rlast_q  <= (rd_cnt == 4'd0);
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        rvalid_q <= 1'b0;
                        rlast_q  <= 1'b0;
                        if (rlast_q) begin
                            rd_state  <= R_IDLE;
                            arready_q <= 1'b1;
                        end else begin
                            rd_state <= R_GAP;
                            rd_idx   <= rd_idx + 1'b1;
                            rd_cnt   <= rd_cnt - 4'd1;
                        end
                    end
                end
                R_GAP: begin
                    rd_state <= R_DATA;
                    rvalid_q <= 1'b1;
                    rlast_q  <= (rd_cnt == 4'd0);
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            wr_state  <= W_IDLE;
            bid_q     <= '0;
            wr_idx    <= '0;
            wr_cnt    <= '0;
            wr_err    <= 1'b0;
            wlast_err <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (aw_hs) begin
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        bid_q     <= S_AXI_AWID;
                        wr_idx    <= aw_idx;
                        wr_cnt    <= S_AXI_AWLEN;
                        wr_err    <= burst_err(S_AXI_AWBURST, S_AXI_AWSIZE);
                        wlast_err <= 1'b0;
                        wr_state  <= W_DATA;
                    end
                end
                W_DATA: begin
                    // Burst length comes from AWLEN; WLAST only feeds the response.
                    if (w_hs) begin
                        wr_idx <= wr_idx + 1'b1;
                        if (wr_cnt == 4'd0) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bresp_q  <= (wr_err || wlast_err || !S_AXI_WLAST) ? RESP_SLVERR : RESP_OKAY;
                            wr_state <= W_RESP;
                        end else begin
                            wr_cnt <= wr_cnt - 4'd1;
                            if (S_AXI_WLAST) begin
                                wlast_err <= 1'b1;
                            end
                        end
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        bvalid_q  <= 1'b0;
                        bresp_q   <= RESP_OKAY;
                        awready_q <= 1'b1;
                        wr_state  <= W_IDLE;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RDATA   = (rvalid_q && !rd_err) ? mem_q : '0;
    assign S_AXI_RID     = rid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RLAST   = rlast_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BID     = bid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_BVALID  = bvalid_q;

endmodule

// File: tb/tb_axi3_hp_slave_mem.sv
// Directed bench for axi3_hp_slave_mem: table of write/read-back bursts plus
// hand sequences for backpressure, early WLAST and mid-burst reset.
module tb_axi3_hp_slave_mem;
    import axi3_pkg::*;

    localparam int RDL = 4;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [31:0] S_AXI_ARADDR;
    logic [5:0]  S_AXI_ARID;
    logic [3:0]  S_AXI_ARLEN;
    logic [2:0]  S_AXI_ARSIZE;
    logic [1:0]  S_AXI_ARBURST;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [63:0] S_AXI_RDATA;
    logic [5:0]  S_AXI_RID;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RLAST;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic [31:0] S_AXI_AWADDR;
    logic [5:0]  S_AXI_AWID;
    logic [3:0]  S_AXI_AWLEN;
    logic [2:0]  S_AXI_AWSIZE;
    logic [1:0]  S_AXI_AWBURST;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [63:0] S_AXI_WDATA;
    logic [7:0]  S_AXI_WSTRB;
    logic        S_AXI_WLAST;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [5:0]  S_AXI_BID;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;

    axi3_hp_slave_mem #(.RD_LATENCY(RDL)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARLEN(S_AXI_ARLEN),
        .S_AXI_ARSIZE(S_AXI_ARSIZE), .S_AXI_ARBURST(S_AXI_ARBURST), .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RID(S_AXI_RID), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWLEN(S_AXI_AWLEN),
        .S_AXI_AWSIZE(S_AXI_AWSIZE), .S_AXI_AWBURST(S_AXI_AWBURST), .S_AXI_AWVALID(S_AXI_AWVALID),
        .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic        do_wr;
        logic [31:0] waddr;
        logic [3:0]  wlen;
        logic [2:0]  wsize;
        logic [1:0]  wburst;
        logic [7:0]  wstrb;
        logic [63:0] wbase;
        logic [63:0] wstep;
        logic [1:0]  bresp;
        logic        do_rd;
        logic [31:0] raddr;
        logic [3:0]  rlen;
        logic [2:0]  rsize;
        logic [1:0]  rburst;
        logic [63:0] rbase;
        logic [63:0] rstep;
        logic [1:0]  rresp;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs[NVEC];

    int tests = 0;
    int fails = 0;

    logic [63:0] wdat[16];
    logic [7:0]  wstb[16];
    logic [63:0] rdat[16];
    logic [1:0]  rrsp[16];
    logic        rlst[16];
    int          roff[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [5:0] id, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int early,
                             output logic [1:0] bresp);
        int t;
        bresp = 2'b11;
        S_AXI_AWADDR = addr; S_AXI_AWID = id; S_AXI_AWLEN = len;
        S_AXI_AWSIZE = size; S_AXI_AWBURST = burst; S_AXI_AWVALID = 1'b1;
        t = 0;
        while (!S_AXI_AWREADY && t < 100) begin tick(); t++; end
        if (t >= 100) begin
            check("aw_timeout", 64'(S_AXI_AWREADY), 64'd1);
            S_AXI_AWVALID = 1'b0;
            return;
        end
        tick();
        S_AXI_AWVALID = 1'b0;
        check("wready_after_aw", 64'(S_AXI_WREADY), 64'd1);
        check("awready_busy", 64'(S_AXI_AWREADY), 64'd0);
        for (int i = 0; i <= int'(len); i++) begin
            S_AXI_WDATA  = wdat[i];
            S_AXI_WSTRB  = wstb[i];
            S_AXI_WLAST  = (i == int'(len)) || (i == early);
            S_AXI_WVALID = 1'b1;
            tick();
            if (i < int'(len)) begin
                check("w_burst_continues", 64'(S_AXI_WREADY), 64'd1);
                check("bvalid_early", 64'(S_AXI_BVALID), 64'd0);
            end
        end
        S_AXI_WVALID = 1'b0;
        S_AXI_WLAST  = 1'b0;
        check("bvalid_latency", 64'(S_AXI_BVALID), 64'd1);
        check("wready_after_last", 64'(S_AXI_WREADY), 64'd0);
        check("bid", 64'(S_AXI_BID), 64'(id));
        bresp = S_AXI_BRESP;
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        check("bvalid_clear", 64'(S_AXI_BVALID), 64'd0);
        check("awready_back", 64'(S_AXI_AWREADY), 64'd1);
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [5:0] id, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int stall,
                            output int nb);
        int t, off, stalls;
        logic [63:0] hold;
        nb = 0;
        hold = '0;
        S_AXI_ARADDR = addr; S_AXI_ARID = id; S_AXI_ARLEN = len;
        S_AXI_ARSIZE = size; S_AXI_ARBURST = burst; S_AXI_ARVALID = 1'b1;
        S_AXI_RREADY = 1'b0;
        t = 0;
        while (!S_AXI_ARREADY && t < 100) begin tick(); t++; end
        if (t >= 100) begin
            check("ar_timeout", 64'(S_AXI_ARREADY), 64'd1);
            S_AXI_ARVALID = 1'b0;
            return;
        end
        tick();
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = (stall == 0);
        check("arready_busy", 64'(S_AXI_ARREADY), 64'd0);
        off = 1; stalls = 0; t = 0;
        while (nb <= int'(len) && t < 300) begin
            if (S_AXI_RVALID) begin
                if (nb == 0 && stalls < stall) begin
                    if (stalls == 0) hold = S_AXI_RDATA;
                    else check("rdata_stable", S_AXI_RDATA, hold);
                    check("rvalid_held", 64'(S_AXI_RVALID), 64'd1);
                    stalls++;
                end else begin
                    S_AXI_RREADY = 1'b1;
                    rdat[nb] = S_AXI_RDATA;
                    rrsp[nb] = S_AXI_RRESP;
                    rlst[nb] = S_AXI_RLAST;
                    roff[nb] = off;
                    check("rid", 64'(S_AXI_RID), 64'(id));
                    nb++;
                end
            end
            tick();
            off++; t++;
        end
        S_AXI_RREADY = 1'b0;
        if (nb <= int'(len)) begin
            check("read_timeout", 64'(nb), 64'(len) + 64'd1);
            return;
        end
        check("rvalid_after_last", 64'(S_AXI_RVALID), 64'd0);
        check("arready_back", 64'(S_AXI_ARREADY), 64'd1);
    endtask

    initial begin
        logic [1:0] br;
        int nb, seen;

        //           wr    waddr        len   sz    bu     strb   wbase                  wstep         bresp  rd    raddr        len   sz    bu     rbase                  rstep         rresp
        vecs[0]  = '{1'b1, 32'h0000_0100, 4'd3, 3'd3, 2'b01, 8'hFF, 64'h11,                64'h11,       2'd0,  1'b1, 32'h0000_0100, 4'd3, 3'd3, 2'b01, 64'h11,                64'h11,       2'd0};
        vecs[1]  = '{1'b1, 32'h0000_0028, 4'd0, 3'd3, 2'b01, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,      2'd0,  1'b0, 32'h0,        4'd0, 3'd3, 2'b01, 64'd0,                 64'd0,        2'd0};
        vecs[2]  = '{1'b1, 32'h0000_0028, 4'd0, 3'd3, 2'b01, 8'h0F, 64'd0,                 64'd0,        2'd0,  1'b1, 32'h0000_0028, 4'd0, 3'd3, 2'b01, 64'hFFFF_FFFF_0000_0000, 64'd0,       2'd0};
        vecs[3]  = '{1'b1, 32'h0000_7FF8, 4'd1, 3'd3, 2'b01, 8'hFF, 64'hA0A0,              64'd1,        2'd0,  1'b1, 32'h0000_0000, 4'd0, 3'd3, 2'b01, 64'hA0A1,              64'd0,        2'd0};
        vecs[4]  = '{1'b0, 32'h0,        4'd0, 3'd3, 2'b01, 8'hFF, 64'd0,                 64'd0,        2'd0,  1'b1, 32'h0000_7FF8, 4'd1, 3'd3, 2'b01, 64'hA0A0,              64'd1,        2'd0};
        vecs[5]  = '{1'b1, 32'h0000_0200, 4'd1, 3'd3, 2'b01, 8'hFF, 64'h5A5A_0000,         64'd1,        2'd0,  1'b1, 32'h0000_0200, 4'd1, 3'd3, 2'b01, 64'h5A5A_0000,         64'd1,        2'd0};
        vecs[6]  = '{1'b1, 32'h0000_0200, 4'd1, 3'd2, 2'b01, 8'hFF, 64'hDEAD,              64'd1,        2'd2,  1'b1, 32'h0000_0200, 4'd1, 3'd3, 2'b01, 64'h5A5A_0000,         64'd1,        2'd0};
        vecs[7]  = '{1'b1, 32'h0000_0200, 4'd0, 3'd3, 2'b00, 8'hFF, 64'h77,                64'd0,        2'd2,  1'b1, 32'h0000_0200, 4'd0, 3'd3, 2'b01, 64'h5A5A_0000,         64'd0,        2'd0};
        vecs[8]  = '{1'b0, 32'h0,        4'd0, 3'd3, 2'b01, 8'hFF, 64'd0,                 64'd0,        2'd0,  1'b1, 32'h0000_0100, 4'd2, 3'd3, 2'b00, 64'd0,                 64'd0,        2'd2};
        vecs[9]  = '{1'b0, 32'h0,        4'd0, 3'd3, 2'b01, 8'hFF, 64'd0,                 64'd0,        2'd0,  1'b1, 32'h0000_0100, 4'd0, 3'd2, 2'b01, 64'd0,                 64'd0,        2'd2};
        vecs[10] = '{1'b1, 32'h0000_0400, 4'd15, 3'd3, 2'b01, 8'hFF, 64'h1000,             64'd3,        2'd0,  1'b1, 32'h0000_0400, 4'd15, 3'd3, 2'b01, 64'h1000,             64'd3,        2'd0};

        ARESETN = 1'b0;
        S_AXI_ARADDR = '0; S_AXI_ARID = '0; S_AXI_ARLEN = '0; S_AXI_ARSIZE = '0;
        S_AXI_ARBURST = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
        S_AXI_AWADDR = '0; S_AXI_AWID = '0; S_AXI_AWLEN = '0; S_AXI_AWSIZE = '0;
        S_AXI_AWBURST = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b0;

        repeat (3) tick();
        check("rst_arready", 64'(S_AXI_ARREADY), 64'd0);
        check("rst_awready", 64'(S_AXI_AWREADY), 64'd0);
        check("rst_rvalid", 64'(S_AXI_RVALID), 64'd0);
        check("rst_wready", 64'(S_AXI_WREADY), 64'd0);
        check("rst_bvalid", 64'(S_AXI_BVALID), 64'd0);
        check("rst_rdata", S_AXI_RDATA, 64'd0);
        ARESETN = 1'b1;
        check("rel1_arready", 64'(S_AXI_ARREADY), 64'd0);
        check("rel1_awready", 64'(S_AXI_AWREADY), 64'd0);
        tick();
        check("rel2_arready", 64'(S_AXI_ARREADY), 64'd1);
        check("rel2_awready", 64'(S_AXI_AWREADY), 64'd1);

        for (int v = 0; v < NVEC; v++) begin
            if (vecs[v].do_wr) begin
                for (int k = 0; k < 16; k++) begin
                    wdat[k] = vecs[v].wbase + 64'(k) * vecs[v].wstep;
                    wstb[k] = vecs[v].wstrb;
                end
                axi_write(vecs[v].waddr, 6'(v + 1), vecs[v].wlen, vecs[v].wsize, vecs[v].wburst, -1, br);
                check($sformatf("v%0d_bresp", v), 64'(br), 64'(vecs[v].bresp));
            end
            if (vecs[v].do_rd) begin
                axi_read(vecs[v].raddr, 6'(v + 32), vecs[v].rlen, vecs[v].rsize, vecs[v].rburst, 0, nb);
                check($sformatf("v%0d_nbeats", v), 64'(nb), 64'(vecs[v].rlen) + 64'd1);
                for (int k = 0; k < nb && k < 16; k++) begin
                    check($sformatf("v%0d_rdata%0d", v, k), rdat[k], vecs[v].rbase + 64'(k) * vecs[v].rstep);
                    check($sformatf("v%0d_rresp%0d", v, k), 64'(rrsp[k]), 64'(vecs[v].rresp));
                    check($sformatf("v%0d_rlast%0d", v, k), 64'(rlst[k]), 64'(k == int'(vecs[v].rlen)));
                    check($sformatf("v%0d_rtime%0d", v, k), 64'(roff[k]), 64'(RDL + 2 * k));
                end
            end
        end

        // RREADY held low for 5 cycles on the first beat.
        axi_read(32'h100, 6'h15, 4'd3, 3'd3, 2'b01, 5, nb);
        check("bp_nbeats", 64'(nb), 64'd4);
        check("bp_rdata0", rdat[0], 64'h11);
        check("bp_rdata3", rdat[3], 64'h44);
        check("bp_rtime0", 64'(roff[0]), 64'(RDL + 5));
        check("bp_rtime1", 64'(roff[1]), 64'(RDL + 7));
        check("bp_rlast3", 64'(rlst[3]), 64'd1);

        // WLAST on the first of three beats: still three beats, SLVERR, data kept.
        wdat[0] = 64'hC1; wdat[1] = 64'hC2; wdat[2] = 64'hC3;
        wstb[0] = 8'hFF;  wstb[1] = 8'hFF;  wstb[2] = 8'hFF;
        axi_write(32'h300, 6'h2A, 4'd2, 3'd3, 2'b01, 0, br);
        check("early_wlast_bresp", 64'(br), 64'(RESP_SLVERR));
        axi_read(32'h300, 6'h2B, 4'd2, 3'd3, 2'b01, 0, nb);
        check("early_wlast_rd0", rdat[0], 64'hC1);
        check("early_wlast_rd2", rdat[2], 64'hC3);
        check("early_wlast_rresp", 64'(rrsp[2]), 64'(RESP_OKAY));

        // Reset while the read is in flight after beat 1 of 4.
        S_AXI_ARADDR = 32'h100; S_AXI_ARID = 6'h07; S_AXI_ARLEN = 4'd3;
        S_AXI_ARSIZE = 3'd3; S_AXI_ARBURST = 2'b01; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
        seen = 0;
        while (!S_AXI_ARREADY && seen < 50) begin tick(); seen++; end
        tick();
        S_AXI_ARVALID = 1'b0;
        seen = 0;
        while (!S_AXI_RVALID && seen < 50) begin tick(); seen++; end
        check("rst_seq_beat0", S_AXI_RDATA, 64'h11);
        tick();
        ARESETN = 1'b0;
        tick();
        check("rst_seq_rvalid", 64'(S_AXI_RVALID), 64'd0);
        check("rst_seq_arready", 64'(S_AXI_ARREADY), 64'd0);
        tick();
        ARESETN = 1'b1;
        check("rst_seq_rel1_arready", 64'(S_AXI_ARREADY), 64'd0);
        check("rst_seq_rel1_rvalid", 64'(S_AXI_RVALID), 64'd0);
        tick();
        check("rst_seq_rel2_arready", 64'(S_AXI_ARREADY), 64'd1);
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (S_AXI_RVALID) seen++;
            tick();
        end
        check("rst_seq_no_rvalid", 64'(seen), 64'd0);
        axi_read(32'h100, 6'h09, 4'd3, 3'd3, 2'b01, 0, nb);
        check("rst_seq_new_nbeats", 64'(nb), 64'd4);
        check("rst_seq_new_rd1", rdat[1], 64'h22);
        check("rst_seq_new_rlast", 64'(rlst[3]), 64'd1);
        check("rst_seq_new_rtime0", 64'(roff[0]), 64'(RDL));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi3_hp_slave_mem.md
# axi3_hp_slave_mem

AXI3 responder that stands in for the Zynq PS HP0 slave port and its DDR, so the accelerator's 64-bit AXI3 memory master can be simulated and hardware-tested standalone. Accepts INCR read and write bursts and serves them from an on-chip byte-writable memory. Read and write channels run independently, each with one outstanding burst.

## Interface
- AXIM_DATA_WIDTH, 64, data bus width; only 64 is supported.
- AXIM_ADDR_WIDTH, 32, byte address width.
- ID_WIDTH, 6, AXI ID width.
- MEM_ADDR_WIDTH, 12, log2 of memory depth in 64-bit words.
- RD_LATENCY, 4, cycles from AR handshake to first RVALID; minimum 1.

Ports:
- ACLK in 1: clock. One clock.
- ARESETN in 1: reset, synchronous, active-low.
- S_AXI_ARADDR/ARID/ARLEN/ARSIZE/ARBURST/ARVALID in 32/6/4/3/2/1; S_AXI_ARREADY out 1.
- S_AXI_RDATA out 64, RID out 6, RRESP out 2, RLAST out 1, RVALID out 1; S_AXI_RREADY in 1.
- S_AXI_AWADDR/AWID/AWLEN/AWSIZE/AWBURST/AWVALID in 32/6/4/3/2/1; S_AXI_AWREADY out 1.
- S_AXI_WDATA in 64, WSTRB in 8, WLAST in 1, WVALID in 1; S_AXI_WREADY out 1. WID is not a port.
- S_AXI_BID out 6, BRESP out 2, BVALID out 1; S_AXI_BREADY in 1.
- CACHE/LOCK/PROT/QOS/USER signals are not ports.

## Operation
- Word index = addr[MEM_ADDR_WIDTH+2:3]; higher bits ignored. Each beat increments the index by 1, wrapping modulo 2^MEM_ADDR_WIDTH. addr[2:0] is ignored.
- Beats per burst = LEN+1 (1..16).
- Error: BURST != INCR (2'b01) or SIZE != 3'b011. Read returns RDATA=0, RRESP=SLVERR (2'b10) on every beat. Write drops all bytes and gives BRESP=SLVERR. Otherwise the response is OKAY (2'b00).
- Read FSM:
  - R_IDLE (ARREADY=1): AR handshake latches ID, index, LEN and error flag, then goes to R_WAIT.
  - R_WAIT: counts RD_LATENCY-1 cycles, then goes to R_DATA.
  - R_DATA: RVALID=1, held with RDATA/RLAST stable until RREADY. After a non-last beat handshake, goes to R_GAP. After the last beat, goes to R_IDLE.
  - R_GAP: one cycle with RVALID=0 while the next word is fetched, then back to R_DATA.
  - RID equals the latched ARID. RLAST=1 only on beat LEN+1.
- Write FSM:
  - W_IDLE (AWREADY=1): AW handshake latches ID, index, LEN and error flag, then goes to W_DATA.
  - W_DATA (WREADY=1): each WVALID handshake writes only the bytes whose WSTRB bit is set.
    - The burst ends on beat count, not on WLAST.
    - WLAST must be 1 on exactly the final beat. Any disagreement sets BRESP=SLVERR, but valid data is still written.
    - After the final beat, goes to W_RESP.
  - W_RESP: BVALID=1 with BID/BRESP held until BREADY, then goes to W_IDLE.
  - W beats presented before the AW handshake are stalled (WREADY=0).
- Memory contents are not initialised by reset.

## Timing
- During reset, and in the first cycle it is deasserted, all outputs are 0. ARREADY and AWREADY are 1 from the second cycle after ARESETN rises.
- Read: AR handshake at cycle T gives the first RVALID at T+RD_LATENCY. With RREADY held high, beat k is at T+RD_LATENCY+2k.
- Write: AW handshake at T gives WREADY=1 from T+1. The last W handshake at cycle U gives BVALID at U+1. AWREADY returns the cycle after the B handshake.
- ARREADY is 0 from the AR handshake until the cycle after the RLAST handshake. AWREADY follows the same rule with respect to the B handshake.
- Same-cycle read fetch and write to the same word: the read returns the old data (read-first). The write is committed.
- ARESETN low mid-burst: both FSMs return to idle at the next edge. Outstanding bursts are abandoned with no R/B completion.

## Structure
- Shared package axi3_pkg holds:
  - BURST_INCR, RESP_OKAY, RESP_SLVERR, SIZE_8B;
  - read/write state enums.
- Sub-module mem_bram_2p: one write port with 8-bit byte enables, one registered read port, read-first, depth 2^MEM_ADDR_WIDTH x 64.
- Top-level body contains the two FSMs, beat counters and latency counter.

## Test plan
- Write 4 beats (AWADDR=0x100, AWLEN=3, WSTRB=0xFF, data 0x11..0x44). Expect BVALID one cycle after the last W, BRESP=0, BID=AWID. Then read ARADDR=0x100, ARLEN=3: expect data 0x11..0x44, RLAST on beat 4, first RVALID at T+4.
- Partial strobe: write 0xFFFF_FFFF_FFFF_FFFF to word 5, then WSTRB=0x0F with data 0. Readback = 0xFFFF_FFFF_0000_0000.
- Wrap: MEM_ADDR_WIDTH=12, AWADDR=0x7FF8, AWLEN=1. The second beat lands at word 0, and readback from 0x0 matches.
- Error: ARBURST=FIXED, ARLEN=2. Expect 3 beats of RDATA=0, RRESP=2, RLAST on the third beat. AWSIZE=2 write: BRESP=2 and memory unchanged.
- Backpressure/WLAST: RREADY low for 5 cycles keeps RVALID/RDATA stable. A write with WLAST asserted early on beat 1 of 3 still takes 3 beats and gives BRESP=2.
- Reset during R_DATA after beat 1 of 4: no further RVALID. ARREADY=1 two cycles after ARESETN rises. A new read then completes normally.
